// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, instruction
// classes, ALU operation codes, datapath select values and opcode/funct fields.
`default_nettype none

package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC      = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_JREG      = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    CLS_MEM_LOAD  = 3'd0,
    CLS_MEM_STORE = 3'd1,
    CLS_ALU_R     = 3'd2,
    CLS_ALU_I     = 3'd3,
    CLS_BRANCH    = 3'd4,
    CLS_JUMP      = 3'd5,
    CLS_JREG      = 3'd6,
    CLS_ILLEGAL   = 3'd7
  } instr_class_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_ADDU = 4'b1000;
  localparam logic [3:0] ALU_SUBU = 4'b1001;
  localparam logic [3:0] ALU_SLL  = 4'b1010;
  localparam logic [3:0] ALU_LUI  = 4'b1011;
  localparam logic [3:0] ALU_SRL  = 4'b1100;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_A      = 2'b11;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_REG   = 2'b01;
  localparam logic [1:0] SRC_A_SHAMT = 2'b10;

  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_BR_OFS = 2'b11;

  localparam logic [1:0] DST_RD  = 2'b00;
  localparam logic [1:0] DST_RT  = 2'b01;
  localparam logic [1:0] DST_R31 = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b10;
  localparam logic [1:0] SIZE_BYTE = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

endpackage

`default_nettype wire

// File: rtl/mc_instr_decode.sv
// Combinational opcode/funct decoder: instruction class plus the per-instruction
// ALU operation, immediate extension, shift, memory size/sign and link flags.
`default_nettype none

module mc_instr_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] iclass,
  output logic [3:0] alu_op,
  output logic       ext_sign,
  output logic       shift_imm,
  output logic [1:0] mem_byte,
  output logic       mem_sign,
  output logic       link
);

  always_comb begin
    iclass    = CLS_ILLEGAL;
    alu_op    = ALU_ADD;
    ext_sign  = 1'b0;
    shift_imm = 1'b0;
    mem_byte  = SIZE_WORD;
    mem_sign  = 1'b0;
    link      = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        iclass = CLS_ALU_R;
        case (funct)
          FN_SLL:  begin alu_op = ALU_SLL; shift_imm = 1'b1; end
          FN_SRL:  begin alu_op = ALU_SRL; shift_imm = 1'b1; end
          FN_SRA:  begin alu_op = ALU_SRA; shift_imm = 1'b1; end
          FN_SLLV: alu_op = ALU_SLL;
          FN_SRLV: alu_op = ALU_SRL;
          FN_SRAV: alu_op = ALU_SRA;
          FN_JR:   iclass = CLS_JREG;
          FN_JALR: begin iclass = CLS_JREG; link = 1'b1; end
          FN_ADD:  alu_op = ALU_ADD;
          FN_ADDU: alu_op = ALU_ADDU;
          FN_SUB:  alu_op = ALU_SUB;
          FN_SUBU: alu_op = ALU_SUBU;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLTU: alu_op = ALU_SLTU;
          default: iclass = CLS_ILLEGAL;
        endcase
      end
      OP_J:    iclass = CLS_JUMP;
      OP_JAL:  begin iclass = CLS_JUMP; link = 1'b1; end
      OP_BEQ,
      OP_BNE:  begin iclass = CLS_BRANCH; alu_op = ALU_SUB; end
      OP_ADDI: begin iclass = CLS_ALU_I; alu_op = ALU_ADD; ext_sign = 1'b1; end
      OP_SLTI: begin iclass = CLS_ALU_I; alu_op = ALU_SLT; ext_sign = 1'b1; end
      OP_ANDI: begin iclass = CLS_ALU_I; alu_op = ALU_AND; end
      OP_ORI:  begin iclass = CLS_ALU_I; alu_op = ALU_OR;  end
      OP_LUI:  begin iclass = CLS_ALU_I; alu_op = ALU_LUI; end
      OP_LB:   begin iclass = CLS_MEM_LOAD; mem_byte = SIZE_BYTE; mem_sign = 1'b1; end
      OP_LH:   begin iclass = CLS_MEM_LOAD; mem_byte = SIZE_HALF; mem_sign = 1'b1; end
      OP_LHU:  begin iclass = CLS_MEM_LOAD; mem_byte = SIZE_HALF; end
      OP_LW:   begin iclass = CLS_MEM_LOAD; mem_byte = SIZE_WORD; mem_sign = 1'b1; end
      OP_SB:   begin iclass = CLS_MEM_STORE; mem_byte = SIZE_BYTE; end
      OP_SH:   begin iclass = CLS_MEM_STORE; mem_byte = SIZE_HALF; end
      OP_SW:   begin iclass = CLS_MEM_STORE; mem_byte = SIZE_WORD; end
      default: iclass = CLS_ILLEGAL;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multi_cycle_controller.sv
// Moore sequencer for the multi-cycle MIPS datapath: state register, next-state
// logic and per-state control decode, with a req/ready memory handshake.
`default_nettype none

module multi_cycle_controller
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic [1:0] mem_byte,
  output logic       mem_sign,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_sign,
  output logic [3:0] alu_op,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] to_reg,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state
);

  state_t     state_r;
  state_t     state_nxt;
  logic [2:0] dec_class;
  logic [3:0] dec_alu_op;
  logic       dec_ext_sign;
  logic       dec_shift_imm;
  logic [1:0] dec_mem_byte;
  logic       dec_mem_sign;
  logic       dec_link;

  mc_instr_decode u_decode (
    .opcode    (opcode),
    .funct     (funct),
    .iclass    (dec_class),
    .alu_op    (dec_alu_op),
    .ext_sign  (dec_ext_sign),
    .shift_imm (dec_shift_imm),
    .mem_byte  (dec_mem_byte),
    .mem_sign  (dec_mem_sign),
    .link      (dec_link)
  );

  always_ff @(posedge clk) begin
    if (rst) state_r <= S_FETCH;
    else     state_r <= state_nxt;
  end

  always_comb begin
    state_nxt = state_r;
    case (state_r)
      S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (dec_class)
          CLS_MEM_LOAD, CLS_MEM_STORE: state_nxt = S_MEM_ADDR;
          CLS_ALU_R, CLS_ALU_I:        state_nxt = S_EXEC;
          CLS_BRANCH:                  state_nxt = S_BRANCH;
          CLS_JUMP:                    state_nxt = S_JUMP;
          CLS_JREG:                    state_nxt = S_JREG;
          default:                     state_nxt = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_nxt = (dec_class == CLS_MEM_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_nxt = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) state_nxt = S_FETCH;
      S_EXEC:      state_nxt = S_ALU_WB;
      default:     state_nxt = S_FETCH;
    endcase
  end

  // Outputs are forced low while rst is high so an abandoned access never completes.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    i_or_d    = 1'b0;
    mem_byte  = SIZE_WORD;
    mem_sign  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_source = PC_SRC_ALU;
    alu_src_a = SRC_A_PC;
    alu_src_b = SRC_B_REG;
    ext_sign  = 1'b0;
    alu_op    = ALU_ADD;
    reg_write = 1'b0;
    reg_dst   = DST_RD;
    to_reg    = WB_ALUOUT;
    retire    = 1'b0;
    illegal   = 1'b0;
    if (!rst) begin
      case (state_r)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRC_B_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = SRC_B_BR_OFS;
          if (dec_class == CLS_ILLEGAL) begin
            illegal = 1'b1;
            retire  = 1'b1;
          end
        end
        S_MEM_ADDR: begin
          alu_src_a = SRC_A_REG;
          alu_src_b = SRC_B_IMM;
          ext_sign  = 1'b1;
          mem_byte  = dec_mem_byte;
          mem_sign  = dec_mem_sign;
        end
        S_MEM_READ: begin
          mem_req  = 1'b1;
          i_or_d   = 1'b1;
          mem_byte = dec_mem_byte;
          mem_sign = dec_mem_sign;
        end
        S_MEM_WB: begin
          reg_write = 1'b1;
          reg_dst   = DST_RT;
          to_reg    = WB_MDR;
          retire    = 1'b1;
          mem_byte  = dec_mem_byte;
          mem_sign  = dec_mem_sign;
        end
        S_MEM_WRITE: begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          i_or_d   = 1'b1;
          mem_byte = dec_mem_byte;
          mem_sign = dec_mem_sign;
          retire   = mem_ready;
        end
        S_EXEC: begin
          alu_src_a = dec_shift_imm ? SRC_A_SHAMT : SRC_A_REG;
          alu_src_b = (dec_class == CLS_ALU_R) ? SRC_B_REG : SRC_B_IMM;
          ext_sign  = dec_ext_sign;
          alu_op    = dec_alu_op;
        end
        S_ALU_WB: begin
          reg_write = 1'b1;
          reg_dst   = (dec_class == CLS_ALU_R) ? DST_RD : DST_RT;
          to_reg    = WB_ALUOUT;
          retire    = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = SRC_A_REG;
          alu_src_b = SRC_B_REG;
          alu_op    = ALU_SUB;
          pc_source = PC_SRC_ALUOUT;
          pc_write  = (opcode == OP_BNE) ? ~zero : zero;
          retire    = 1'b1;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = PC_SRC_JUMP;
          retire    = 1'b1;
          if (dec_link) begin
            reg_write = 1'b1;
            reg_dst   = DST_R31;
            to_reg    = WB_PC;
          end
        end
        S_JREG: begin
          pc_write  = 1'b1;
          pc_source = PC_SRC_A;
          retire    = 1'b1;
          if (dec_link) begin
            reg_write = 1'b1;
            reg_dst   = DST_RD;
            to_reg    = WB_PC;
          end
        end
        default: ;
      endcase
    end
  end

  assign state = rst ? 4'd0 : state_r;

endmodule

`default_nettype wire

// File: doc/multi_cycle_controller.md
# multi_cycle_controller

Multi-cycle sequencer for the MIPS datapath that reuses one ALU and one unified instruction/data memory across several cycles per instruction. Moore-style FSM: walks each instruction through FETCH, DECODE and class-specific execute, memory and write-back states, and drives every mux select, write enable and ALU operation. Talks to memory through a req/ready handshake that tolerates wait states. Sits beside the datapath's IR, A, B, ALUOut and MDR registers; opcode, funct and zero come back from the datapath.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag, same cycle.
- mem_ready  in  1  memory accepts/completes the current request this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write.
- i_or_d  out  1  address select: 0 = PC, 1 = ALUOut.
- mem_byte  out  2  access size: 00 word, 10 half, 11 byte.
- mem_sign  out  1  sign-extend loaded data.
- ir_write  out  1  latch IR.
- pc_write  out  1  latch PC.
- pc_source  out  2  next-PC source: 00 ALU result, 01 ALUOut, 10 jump target, 11 A.
- alu_src_a  out  2  ALU A input: 00 PC, 01 A, 10 zero-extended shamt.
- alu_src_b  out  2  ALU B input: 00 B, 01 constant 4, 10 extended imm16, 11 sign-extended imm16 shifted left 2.
- ext_sign  out  1  imm16 extension: 1 = sign, 0 = zero.
- alu_op  out  4  ALU operation code.
- reg_write  out  1  register-file write enable.
- reg_dst  out  2  destination register: 00 rd, 01 rt, 10 r31.
- to_reg  out  2  write-back source: 00 ALUOut, 01 MDR, 10 PC.
- retire  out  1  one-cycle pulse on the last cycle of each instruction.
- illegal  out  1  one-cycle pulse when DECODE sees an unsupported encoding.
- state  out  4  current state, for debug.

## Operation
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC=6, ALU_WB=7, BRANCH=8, JUMP=9, JREG=10.
- All outputs not listed for a state are 0.
- **FETCH:**
  - Drives mem_req=1, i_or_d=0, alu_src_a=00, alu_src_b=01, alu_op=ADD.
  - Holds these until mem_ready=1.
  - In the mem_ready cycle it also drives ir_write=1, pc_write=1 and pc_source=00, then moves to DECODE.
- **DECODE:** computes the branch target into ALUOut with alu_src_a=00, alu_src_b=11, alu_op=ADD. Next state:
  - loads and stores → MEM_ADDR
  - R-type ALU ops, shifts, addi, andi, ori, slti, lui → EXEC
  - beq, bne → BRANCH
  - j, jal → JUMP
  - jr, jalr → JREG
  - anything else → illegal=1, retire=1, back to FETCH (executes as a NOP).
- **MEM_ADDR:** alu_src_a=01, alu_src_b=10, ext_sign=1, alu_op=ADD. Next state is MEM_READ for loads, MEM_WRITE for stores.
- **MEM_READ:** mem_req=1, i_or_d=1; waits for mem_ready, then goes to MEM_WB.
- **MEM_WB:** reg_write=1, reg_dst=01, to_reg=01, retire=1.
- **MEM_WRITE:** mem_req=1, mem_we=1, i_or_d=1; waits for mem_ready. retire=1 in the mem_ready cycle, then FETCH.
- **mem_byte / mem_sign:** valid in the MEM_* states.
  - lb, sb: mem_byte=11. lh, lhu, sh: mem_byte=10. lw, sw: mem_byte=00.
  - mem_sign=1 for lw, lh, lb.
- **EXEC:**
  - alu_src_a=10 for sll/srl/sra, otherwise 01.
  - alu_src_b=00 for R-type, otherwise 10.
  - ext_sign=1 for addi and slti only.
- **ALU_WB:** reg_write=1, to_reg=00, reg_dst=00 for R-type and 01 for I-type, retire=1.
- **BRANCH:**
  - Drives alu_src_a=01, alu_src_b=00, alu_op=SUB, pc_source=01, retire=1.
  - pc_write = (beq & zero) | (bne & ~zero).
- **JUMP:**
  - pc_write=1, pc_source=10, retire=1.
  - jal additionally drives reg_write=1, reg_dst=10, to_reg=10 (PC already holds PC+4).
- **JREG:**
  - pc_write=1, pc_source=11, retire=1.
  - jalr additionally drives reg_write=1, reg_dst=00, to_reg=10.
- **alu_op codes:** ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, NOR 0101, SLT 0110, SLTU 0111, ADDU 1000, SUBU 1001, SLL 1010, LUI 1011, SRL 1100, SRA 1101.
  - Variable shifts map to the same code as their immediate forms.
  - andi→AND, ori→OR, slti→SLT, addi→ADD.

## Timing
- **Latency, zero wait states (CPI):** branch, jump and jreg 3; R-type and immediate ops 4; store 4; load 5. Each mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE adds 1.
- **Memory handshake:**
  - mem_req, mem_we, i_or_d and mem_byte stay stable while mem_ready=0.
  - mem_ready is ignored when mem_req=0.
  - mem_ready may be high in the first request cycle (zero-wait).
- **Reset:**
  - While rst=1, every output is 0, including mem_req and state.
  - The first cycle after rst falls is FETCH with mem_req=1.
  - rst during a wait state abandons the access; no pc_write, reg_write or retire is issued.
- **Decode-time inputs:** opcode and funct are sampled only in DECODE and later states; IR does not change until the next FETCH completes.

## Structure
- Package mc_ctrl_pkg holds:
  - the state enum (4-bit);
  - ALU_OP codes;
  - select encodings for pc_source, alu_src_a, alu_src_b, reg_dst, to_reg and mem_byte;
  - opcode and funct constants.
- One sub-module, mc_instr_decode (purely combinational):
  - maps opcode/funct to an instruction class (MEM_LOAD, MEM_STORE, ALU_R, ALU_I, BRANCH, JUMP, JREG, ILLEGAL);
  - also produces alu_op, ext_sign, the shift flag, mem_byte, mem_sign and the link flag.
- The FSM register and the output decode live in the top module.

## Test plan
- **add $3,$1,$2 (0x00221820), mem_ready always 1:** states 0,1,6,7. reg_write=1 with reg_dst=00 in cycle 4; retire exactly once; alu_op=0000 in EXEC.
- **lw $5,8($4), with mem_ready held 0 for 2 cycles in MEM_READ:**
  - states 0,1,2,3,3,3,4;
  - mem_req, i_or_d=1 and mem_byte=00 stable throughout;
  - reg_write with to_reg=01 and reg_dst=01 on cycle 7.
- **beq:** with zero=1, pc_write=1 and pc_source=01 in BRANCH; repeat with zero=0 and require pc_write=0. bne gives the inverse.
- **jal 0x100:** JUMP cycle shows pc_write=1, pc_source=10, reg_write=1, reg_dst=10, to_reg=10. **jalr $31,$9:** pc_source=11, reg_dst=00.
- **Unsupported opcode 0x3F:** illegal and retire pulse for 1 cycle in DECODE; next state FETCH; no pc_write or reg_write in that cycle.
- **Reset mid-operation:** rst asserted during a MEM_WRITE wait → next cycle all outputs 0. After release, FETCH with mem_req=1, and no store is ever acknowledged (mem_we never high together with mem_ready for that store).
